// File: rtl/regfile_dbg.sv
// regfile_dbg: debug access master for the microcoded 65C02 register file.
//
// Sits between the microcode sequencer and the register file. While idle the
// CPU owns the regfile ports. An accepted debug command freezes the CPU for
// one cycle (ACCESS), performs exactly one regfile read or write, and then
// spends one cycle in RESP before the next command can be taken.
//
// Ports:
//   clk, RST            system clock, synchronous active-high reset
//   cpu_op/DI/rdy       microcode regfile op, write data and bus ready
//   cpu_hold            stalls the CPU (ANDed into its rdy externally)
//   rf_op/DI/rdy        muxed op, write data and write gate to the regfile
//   rf_DO               asynchronous regfile read data
//   dbg_valid/ready     command handshake
//   dbg_we/addr/wdata   command: write flag, address, write data
//   dbg_rvalid/rdata    one-cycle read response pulse, data held until next read
//
// Optional feature, enabled by defining REGFILE_DBG_SNAPSHOT_EN:
//   dbg_snap            with dbg_valid, requests a 4-cycle snapshot of X/Y/A/S
//   dbg_snap_data       {S, A, Y, X} captured by the last snapshot
module regfile_dbg #(
    parameter logic [3:0] ZERO_ADDR = 4'h7
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [6:0]  cpu_op,
    input  logic [7:0]  cpu_DI,
    input  logic        cpu_rdy,
    output logic        cpu_hold,
    output logic [6:0]  rf_op,
    output logic [7:0]  rf_DI,
    output logic        rf_rdy,
    input  logic [7:0]  rf_DO,
    input  logic        dbg_valid,
    output logic        dbg_ready,
    input  logic        dbg_we,
    input  logic [3:0]  dbg_addr,
    input  logic [7:0]  dbg_wdata,
    output logic        dbg_rvalid,
    output logic [7:0]  dbg_rdata
`ifdef REGFILE_DBG_SNAPSHOT_EN
    ,
    input  logic        dbg_snap,
    output logic [31:0] dbg_snap_data
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
`ifdef REGFILE_DBG_SNAPSHOT_EN
        ,
        SNAP   = 2'd3
`endif
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        cmd_we_r;
    logic [3:0]  cmd_addr_r;
    logic [7:0]  cmd_wdata_r;
    logic [7:0]  rdata_r;
    logic        accept_s;
    logic        dbg_ready_s;
    logic        cpu_hold_s;
    logic        rvalid_s;
    logic [6:0]  rf_op_s;
    logic [7:0]  rf_di_s;
    logic        rf_rdy_s;
`ifdef REGFILE_DBG_SNAPSHOT_EN
    logic [1:0]  snap_cnt_r;
    logic [31:0] snap_data_r;
`endif

    assign accept_s = dbg_valid & dbg_ready_s;

    // State register.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: IDLE -> ACCESS (or SNAP) -> RESP -> IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
`ifdef REGFILE_DBG_SNAPSHOT_EN
                    if (dbg_snap) begin
                        state_next_s = SNAP;
                    end else begin
                        state_next_s = ACCESS;
                    end
`else
                    state_next_s = ACCESS;
`endif
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS: state_next_s = RESP;
            RESP:   state_next_s = IDLE;
`ifdef REGFILE_DBG_SNAPSHOT_EN
            SNAP: begin
                if (snap_cnt_r == 2'd3) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = SNAP;
                end
            end
`endif
            default: state_next_s = IDLE;
        endcase
    end

    // Command latch; a reset leaves a harmless read of address 0 behind.
    always_ff @(posedge clk) begin
        if (RST) begin
            cmd_we_r    <= 1'b0;
            cmd_addr_r  <= 4'h0;
            cmd_wdata_r <= 8'h00;
        end else if (accept_s) begin
`ifdef REGFILE_DBG_SNAPSHOT_EN
            // A snapshot is a read sequence, so it answers with rvalid.
            cmd_we_r    <= dbg_we & ~dbg_snap;
`else
            cmd_we_r    <= dbg_we;
`endif
            cmd_addr_r  <= dbg_addr;
            cmd_wdata_r <= dbg_wdata;
        end else begin
            cmd_we_r    <= cmd_we_r;
            cmd_addr_r  <= cmd_addr_r;
            cmd_wdata_r <= cmd_wdata_r;
        end
    end

    // Read data capture; writes never disturb the last read value.
    always_ff @(posedge clk) begin
        if (RST) begin
            rdata_r <= 8'h00;
        end else if ((state_r == ACCESS) && !cmd_we_r) begin
            rdata_r <= rf_DO;
`ifdef REGFILE_DBG_SNAPSHOT_EN
        end else if ((state_r == SNAP) && (snap_cnt_r == 2'd0)) begin
            rdata_r <= rf_DO;
`endif
        end else begin
            rdata_r <= rdata_r;
        end
    end

`ifdef REGFILE_DBG_SNAPSHOT_EN
    // Snapshot step counter and progressive {S, A, Y, X} capture.
    always_ff @(posedge clk) begin
        if (RST) begin
            snap_cnt_r  <= 2'd0;
            snap_data_r <= 32'h0000_0000;
        end else if (state_r == SNAP) begin
            snap_cnt_r <= snap_cnt_r + 2'd1;
            case (snap_cnt_r)
                2'd0:    snap_data_r[7:0]   <= rf_DO;
                2'd1:    snap_data_r[15:8]  <= rf_DO;
                2'd2:    snap_data_r[23:16] <= rf_DO;
                2'd3:    snap_data_r[31:24] <= rf_DO;
                default: snap_data_r        <= snap_data_r;
            endcase
        end else begin
            snap_cnt_r  <= 2'd0;
            snap_data_r <= snap_data_r;
        end
    end

    assign dbg_snap_data = snap_data_r;
`endif

    // Output decode: the CPU owns the regfile except in ACCESS/SNAP.
    always_comb begin
        dbg_ready_s = 1'b0;
        cpu_hold_s  = 1'b0;
        rvalid_s    = 1'b0;
        rf_op_s     = cpu_op;
        rf_di_s     = cpu_DI;
        rf_rdy_s    = cpu_rdy;
        case (state_r)
            IDLE: dbg_ready_s = 1'b1;
            ACCESS: begin
                cpu_hold_s = 1'b1;
                if (cmd_we_r) begin
                    // Read field points at the zero slot so the op is side-effect free.
                    rf_op_s  = {1'b1, cmd_addr_r[1:0], ZERO_ADDR};
                    rf_di_s  = cmd_wdata_r;
                    rf_rdy_s = 1'b1;
                end else begin
                    rf_op_s  = {1'b0, 2'b00, cmd_addr_r};
                    rf_di_s  = 8'h00;
                    rf_rdy_s = 1'b0;
                end
            end
            RESP: rvalid_s = ~cmd_we_r;
`ifdef REGFILE_DBG_SNAPSHOT_EN
            SNAP: begin
                cpu_hold_s = 1'b1;
                rf_op_s    = {1'b0, 2'b00, 2'b00, snap_cnt_r};
                rf_di_s    = 8'h00;
                rf_rdy_s   = 1'b0;
            end
`endif
            default: begin
                dbg_ready_s = 1'b0;
                cpu_hold_s  = 1'b0;
            end
        endcase
    end

    assign dbg_ready  = dbg_ready_s;
    assign cpu_hold   = cpu_hold_s;
    assign dbg_rvalid = rvalid_s;
    assign dbg_rdata  = rdata_r;
    assign rf_op      = rf_op_s;
    assign rf_DI      = rf_di_s;
    // No regfile write may happen in a cycle where reset is asserted.
    assign rf_rdy     = rf_rdy_s & ~RST;

endmodule

// File: tb/tb_regfile_dbg.sv
// Self-checking bench for regfile_dbg with a small behavioural regfile.
module tb_regfile_dbg;

    logic        clk;
    logic        RST;
    logic [6:0]  cpu_op;
    logic [7:0]  cpu_DI;
    logic        cpu_rdy;
    logic        cpu_hold;
    logic [6:0]  rf_op;
    logic [7:0]  rf_DI;
    logic        rf_rdy;
    logic [7:0]  rf_DO;
    logic        dbg_valid;
    logic        dbg_ready;
    logic        dbg_we;
    logic [3:0]  dbg_addr;
    logic [7:0]  dbg_wdata;
    logic        dbg_rvalid;
    logic [7:0]  dbg_rdata;
`ifdef REGFILE_DBG_SNAPSHOT_EN
    logic        dbg_snap;
    logic [31:0] dbg_snap_data;
`endif

    regfile_dbg dut (
        .clk(clk), .RST(RST),
        .cpu_op(cpu_op), .cpu_DI(cpu_DI), .cpu_rdy(cpu_rdy), .cpu_hold(cpu_hold),
        .rf_op(rf_op), .rf_DI(rf_DI), .rf_rdy(rf_rdy), .rf_DO(rf_DO),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata)
`ifdef REGFILE_DBG_SNAPSHOT_EN
        ,
        .dbg_snap(dbg_snap), .dbg_snap_data(dbg_snap_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural regfile: X/Y/A/S writable, constant slots fixed.
    logic       model_init;
    logic [7:0] rf_regs [4];

    always @(posedge clk) begin
        if (model_init) begin
            rf_regs[0] <= 8'h02;
            rf_regs[1] <= 8'h03;
            rf_regs[2] <= 8'h41;
            rf_regs[3] <= 8'hFF;
        end else if (rf_rdy && rf_op[6]) begin
            rf_regs[rf_op[5:4]] <= rf_DI;
        end
    end

    always_comb begin
        case (rf_op[3:0])
            4'h0:    rf_DO = rf_regs[0];
            4'h1:    rf_DO = rf_regs[1];
            4'h2:    rf_DO = rf_regs[2];
            4'h3:    rf_DO = rf_regs[3];
            4'h5:    rf_DO = 8'h01;
            4'h6:    rf_DO = 8'hFF;
            4'h8:    rf_DO = 8'hF9;
            4'h9:    rf_DO = 8'hFB;
            4'hA:    rf_DO = 8'hFD;
            default: rf_DO = 8'h00;
        endcase
    end

    int         tests;
    int         fails;
    logic [7:0] sb_q [$];
    logic [7:0] last_rd;

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
        logic       rdy;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle and score any read response against the queue.
    task automatic tick();
        logic [7:0] e;
        @(posedge clk);
        #1;
        if (dbg_rvalid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rvalid", 32'(dbg_rvalid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("rdata", 32'(dbg_rdata), 32'(e));
            end
        end
    endtask

    // Wait (bounded) for ready, then present a command for one cycle.
    task automatic issue(input logic we, input logic [3:0] addr, input logic [7:0] wd, input logic [7:0] exp);
        int n;
        n = 0;
        while (!dbg_ready && n < 10) begin
            tick();
            n++;
        end
        if (!dbg_ready) check("ready_timeout", 32'(dbg_ready), 32'd1);
        dbg_valid = 1'b1;
        dbg_we    = we;
        dbg_addr  = addr;
        dbg_wdata = wd;
        if (!we) sb_q.push_back(exp);
        tick();
        dbg_valid = 1'b0;
    endtask

    // Full command with ACCESS/RESP phase checks.
    task automatic run_cmd(input logic we, input logic [3:0] addr, input logic [7:0] wd, input logic [7:0] exp);
        #1;
        check("idle_pass_op", 32'(rf_op), 32'(cpu_op));
        check("idle_pass_rdy", 32'(rf_rdy), 32'(cpu_rdy));
        issue(we, addr, wd, exp);
        check("acc_hold", 32'(cpu_hold), 32'd1);
        check("acc_ready", 32'(dbg_ready), 32'd0);
        check("acc_rf_op", 32'(rf_op), we ? 32'({1'b1, addr[1:0], 4'h7}) : 32'({3'b000, addr}));
        check("acc_rf_di", 32'(rf_DI), we ? 32'(wd) : 32'd0);
        check("acc_rf_rdy", 32'(rf_rdy), 32'(we));
        tick();
        check("resp_hold", 32'(cpu_hold), 32'd0);
        check("resp_rvalid", 32'(dbg_rvalid), 32'(!we));
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        if (we) check("rdata_hold", 32'(dbg_rdata), 32'(last_rd));
        else last_rd = exp;
        tick();
        check("back_ready", 32'(dbg_ready), 32'd1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        last_rd = 8'h00;
        vecs[0]  = '{1'b0, 4'h2, 8'h00, 8'h41, 1'b1};
        vecs[1]  = '{1'b1, 4'h0, 8'h5A, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 4'h0, 8'h00, 8'h5A, 1'b1};
        vecs[3]  = '{1'b0, 4'h1, 8'h00, 8'h03, 1'b1};
        vecs[4]  = '{1'b0, 4'h2, 8'h00, 8'h41, 1'b0};
        vecs[5]  = '{1'b0, 4'h3, 8'h00, 8'hFF, 1'b1};
        vecs[6]  = '{1'b0, 4'h5, 8'h00, 8'h01, 1'b1};
        vecs[7]  = '{1'b0, 4'h6, 8'h00, 8'hFF, 1'b1};
        vecs[8]  = '{1'b1, 4'h2, 8'h10, 8'h00, 1'b1};
        vecs[9]  = '{1'b0, 4'h2, 8'h00, 8'h10, 1'b1};
        vecs[10] = '{1'b0, 4'h8, 8'h00, 8'hF9, 1'b1};
        vecs[11] = '{1'b0, 4'hA, 8'h00, 8'hFD, 1'b1};
        vecs[12] = '{1'b1, 4'h7, 8'h3C, 8'h00, 1'b1};
        vecs[13] = '{1'b0, 4'h3, 8'h00, 8'h3C, 1'b1};

        RST = 1'b1; model_init = 1'b1;
        cpu_op = 7'h47; cpu_DI = 8'hEE; cpu_rdy = 1'b1;
        dbg_valid = 1'b0; dbg_we = 1'b0; dbg_addr = 4'h0; dbg_wdata = 8'h00;
`ifdef REGFILE_DBG_SNAPSHOT_EN
        dbg_snap = 1'b0;
`endif
        tick();
        check("rst_rf_rdy_guard", 32'(rf_rdy), 32'd0);
        check("rst_rdata", 32'(dbg_rdata), 32'd0);
        check("rst_rvalid", 32'(dbg_rvalid), 32'd0);
        tick();
        RST = 1'b0; model_init = 1'b0; cpu_op = 7'h07;
        tick();
        check("post_rst_ready", 32'(dbg_ready), 32'd1);
        check("post_rst_hold", 32'(cpu_hold), 32'd0);

        for (int i = 0; i < 14; i++) begin
            cpu_rdy = vecs[i].rdy;
            run_cmd(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
        end
        cpu_rdy = 1'b1;

        // CPU write of Y attempted during ACCESS must not land; it lands in RESP.
        issue(1'b0, 4'h1, 8'h00, 8'h03);
        cpu_op = 7'h50; cpu_DI = 8'hAA;
        #1;
        check("iso_rf_op", 32'(rf_op), 32'h01);
        check("iso_rf_rdy", 32'(rf_rdy), 32'd0);
        tick();
        check("iso_resp_rf_op", 32'(rf_op), 32'h50);
        check("iso_resp_rf_rdy", 32'(rf_rdy), 32'd1);
        tick();
        cpu_op = 7'h07; cpu_DI = 8'h00;
        last_rd = 8'h03;
        run_cmd(1'b0, 4'h1, 8'h00, 8'hAA);

        // Reset during a write ACCESS: no write, no rvalid.
        issue(1'b1, 4'h0, 8'h77, 8'h00);
        RST = 1'b1;
        #1;
        check("mid_rst_rf_rdy", 32'(rf_rdy), 32'd0);
        tick();
        RST = 1'b0;
        check("mid_rst_ready", 32'(dbg_ready), 32'd1);
        check("mid_rst_hold", 32'(cpu_hold), 32'd0);
        check("mid_rst_rdata", 32'(dbg_rdata), 32'd0);
        tick();
        check("mid_rst_no_rvalid", 32'(dbg_rvalid), 32'd0);
        last_rd = 8'h00;
        run_cmd(1'b0, 4'h0, 8'h00, 8'h5A);

`ifdef REGFILE_DBG_SNAPSHOT_EN
        RST = 1'b1; model_init = 1'b1;
        tick();
        tick();
        RST = 1'b0; model_init = 1'b0;
        tick();
        check("snap_rst_data", dbg_snap_data, 32'd0);
        dbg_valid = 1'b1; dbg_snap = 1'b1; dbg_we = 1'b1;
        sb_q.push_back(8'h02);
        tick();
        dbg_valid = 1'b0; dbg_snap = 1'b0; dbg_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("snap_hold", 32'(cpu_hold), 32'd1);
            check("snap_rf_op", 32'(rf_op), 32'(k));
            tick();
        end
        check("snap_rvalid", 32'(dbg_rvalid), 32'd1);
        check("snap_data", dbg_snap_data, 32'hFF41_0302);
        check("snap_drained", 32'(sb_q.size()), 32'd0);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
